seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg7_to_bcd.sv | 32 +++
 rtl/seg_scan_decoder.sv | 148 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment pattern constants, digit codes and FSM states for the scan decoder
package seg_pkg;

  // Patterns are {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_ILLEGAL = 4'hE;

  typedef enum logic {
    S_TRACK = 1'b0,
    S_EMIT  = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational 7-segment pattern to digit value decode with legal flag
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       legal
);

  always_comb begin
    value = CODE_ILLEGAL;
    legal = 1'b1;
    case (seg)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: value = CODE_BLANK;
      default: begin
        value = CODE_ILLEGAL;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers complete digit frames from a multiplexed 7-segment scan
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGIT = 6,
  parameter int SETTLE    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             i_seg,
  input  logic                   i_seg_dp,
  input  logic [NUM_DIGIT-1:0]   i_seg_enb,
  output logic [4*NUM_DIGIT-1:0] o_digits,
  output logic [NUM_DIGIT-1:0]   o_dp,
  output logic                   o_frame_vld,
  output logic                   o_frame_err,
  output logic [7:0]             o_frame_cnt
);

  localparam logic [7:0]           SETTLE_C  = 8'(SETTLE);
  localparam logic [7:0]           SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [NUM_DIGIT-1:0] SEL_ONE   = NUM_DIGIT'(1);

  logic [6:0]             seg_q;
  logic                   dp_q;
  logic [NUM_DIGIT-1:0]   enb_q;
  logic [NUM_DIGIT-1:0]   enb_prev;
  logic [7:0]             stab_cnt;
  logic [NUM_DIGIT-1:0]   mask;
  logic [NUM_DIGIT-1:0]   mask_base;
  logic [NUM_DIGIT-1:0]   mask_next;
  logic                   err_flag;
  logic                   err_base;
  logic                   err_next;
  logic [4*NUM_DIGIT-1:0] dig_buf;
  logic [NUM_DIGIT-1:0]   dp_buf;
  state_t                 state;
  state_t                 state_next;
  logic                   emit;
  logic [3:0]             dec_value;
  logic                   dec_legal;
  logic                   stable;
  logic                   capture;
  logic                   sel_multi;
  logic                   cap_onehot;
  logic                   cap_multi;

  seg7_to_bcd u_dec (
    .seg   (seg_q),
    .value (dec_value),
    .legal (dec_legal)
  );

  assign stable     = (enb_q == enb_prev);
  // Fires only on the edge where the counter steps into SETTLE, so once per stable period.
  assign capture    = stable && (stab_cnt == SETTLE_M1);
  assign sel_multi  = ((enb_q & (enb_q - SEL_ONE)) != '0);
  assign cap_multi  = capture && sel_multi;
  assign cap_onehot = capture && (enb_q != '0) && !sel_multi;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= '0;
      dp_q     <= 1'b0;
      enb_q    <= '0;
      enb_prev <= '0;
      stab_cnt <= '0;
    end else begin
      seg_q    <= i_seg;
      dp_q     <= i_seg_dp;
      enb_q    <= i_seg_enb;
      enb_prev <= enb_q;
      if (!stable) begin
        stab_cnt <= '0;
      end else if (stab_cnt != SETTLE_C) begin
        stab_cnt <= stab_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_TRACK;
      mask     <= '0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_next;
      mask     <= mask_next;
      err_flag <= err_next;
    end
  end

  // The emit cycle clears the frame state, but a capture landing in it seeds the next frame.
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    mask_base  = mask;
    err_base   = err_flag;
    case (state)
      S_TRACK: ;
      S_EMIT: begin
        emit       = 1'b1;
        mask_base  = '0;
        err_base   = 1'b0;
        state_next = S_TRACK;
      end
      default: state_next = S_TRACK;
    endcase
    mask_next = mask_base | (cap_onehot ? enb_q : '0);
    err_next  = err_base | cap_multi | (cap_onehot && !dec_legal);
    if ((state == S_TRACK) && (&mask_next)) begin
      state_next = S_EMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_buf <= {NUM_DIGIT{CODE_BLANK}};
      dp_buf  <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGIT; i++) begin
        if (cap_onehot && enb_q[i]) begin
          dig_buf[4*i +: 4] <= dec_value;
          dp_buf[i]         <= dp_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_digits    <= {NUM_DIGIT{CODE_BLANK}};
      o_dp        <= '0;
      o_frame_vld <= 1'b0;
      o_frame_err <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_frame_vld <= emit;
      if (emit) begin
        o_digits    <= dig_buf;
        o_dp        <= dp_buf;
        o_frame_err <= err_flag;
        o_frame_cnt <= o_frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;
  import seg_pkg::*;

  logic        clk;
  logic        rst;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic [5:0]  i_seg_enb;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic        o_frame_vld;
  logic        o_frame_err;
  logic [7:0]  o_frame_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          frames  = 0;
  int          f0;
  logic [23:0] last_digits;
  logic [5:0]  last_dp;
  logic        last_err;
  logic [7:0]  last_cnt;

  seg_scan_decoder #(.NUM_DIGIT(6), .SETTLE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_seg       (i_seg),
    .i_seg_dp    (i_seg_dp),
    .i_seg_enb   (i_seg_enb),
    .o_digits    (o_digits),
    .o_dp        (o_dp),
    .o_frame_vld (o_frame_vld),
    .o_frame_err (o_frame_err),
    .o_frame_cnt (o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_frame_vld) begin
      frames      = frames + 1;
      last_digits = o_digits;
      last_dp     = o_dp;
      last_err    = o_frame_err;
      last_cnt    = o_frame_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic show(input logic [5:0] sel, input logic [6:0] pat, input logic dp, input int cyc);
    i_seg_enb = sel;
    i_seg     = pat;
    i_seg_dp  = dp;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic scan(input logic [41:0] pats, input logic [5:0] dps, input int hold);
    logic [5:0] s;
    for (int i = 0; i < 6; i++) begin
      s = 6'b000001 << i;
      show(s, pats[7*i +: 7], dps[i], hold);
    end
    show(6'b0, SEG_BLANK, 1'b0, 6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    show(6'b0, SEG_BLANK, 1'b0, 3);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    i_seg     = '0;
    i_seg_dp  = 1'b0;
    i_seg_enb = '0;
    @(negedge clk);
    do_reset();

    check("rst_digits", 32'(o_digits), 32'hFFFFFF);
    check("rst_dp", 32'(o_dp), 32'h0);
    check("rst_vld", 32'(o_frame_vld), 32'h0);
    check("rst_err", 32'(o_frame_err), 32'h0);
    check("rst_cnt", 32'(o_frame_cnt), 32'h0);

    // Basic scan of 1..6
    f0 = frames;
    scan({SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1}, 6'b0, 8);
    check("basic_frames", 32'(frames - f0), 32'd1);
    check("basic_digits", 32'(last_digits), 32'h654321);
    check("basic_err", 32'(last_err), 32'h0);
    check("basic_cnt", 32'(last_cnt), 32'd1);
    check("basic_dp", 32'(last_dp), 32'h0);
    show(6'b0, SEG_BLANK, 1'b0, 20);
    check("hold_digits", 32'(o_digits), 32'h654321);
    check("hold_vld", 32'(o_frame_vld), 32'h0);

    // Digit 2 held too briefly, then completed later
    f0 = frames;
    show(6'b000001, SEG_7, 1'b0, 8);
    show(6'b000010, SEG_7, 1'b0, 8);
    show(6'b000100, SEG_0, 1'b0, 3);
    show(6'b001000, SEG_7, 1'b0, 8);
    show(6'b010000, SEG_7, 1'b0, 8);
    show(6'b100000, SEG_7, 1'b0, 8);
    show(6'b0, SEG_BLANK, 1'b0, 6);
    check("short_noframe", 32'(frames - f0), 32'd0);
    show(6'b000100, SEG_8, 1'b0, 8);
    show(6'b0, SEG_BLANK, 1'b0, 6);
    check("short_frame", 32'(frames - f0), 32'd1);
    check("short_digits", 32'(last_digits), 32'h777877);
    check("short_err", 32'(last_err), 32'h0);
    check("short_cnt", 32'(last_cnt), 32'd2);

    // Illegal pattern on digit 3
    f0 = frames;
    scan({SEG_5, SEG_4, 7'h55, SEG_2, SEG_1, SEG_0}, 6'b0, 8);
    check("illegal_frames", 32'(frames - f0), 32'd1);
    check("illegal_digits", 32'(last_digits), 32'h54E210);
    check("illegal_err", 32'(last_err), 32'h1);
    check("illegal_cnt", 32'(last_cnt), 32'd3);

    // Multi-hot select mid-scan must not overwrite slots 0/1
    f0 = frames;
    show(6'b000001, SEG_1, 1'b0, 8);
    show(6'b000010, SEG_2, 1'b0, 8);
    show(6'b000011, SEG_9, 1'b1, 8);
    show(6'b000100, SEG_3, 1'b0, 8);
    show(6'b001000, SEG_4, 1'b0, 8);
    show(6'b010000, SEG_5, 1'b0, 8);
    show(6'b100000, SEG_6, 1'b0, 8);
    show(6'b0, SEG_BLANK, 1'b0, 6);
    check("multi_frames", 32'(frames - f0), 32'd1);
    check("multi_digits", 32'(last_digits), 32'h654321);
    check("multi_dp", 32'(last_dp), 32'h0);
    check("multi_err", 32'(last_err), 32'h1);
    check("multi_cnt", 32'(last_cnt), 32'd4);

    // Reset mid-frame discards partial captures
    show(6'b000001, SEG_5, 1'b0, 8);
    show(6'b000010, SEG_5, 1'b0, 8);
    show(6'b000100, SEG_5, 1'b0, 8);
    f0 = frames;
    do_reset();
    check("midrst_cnt", 32'(o_frame_cnt), 32'd0);
    check("midrst_digits", 32'(o_digits), 32'hFFFFFF);
    scan({6{SEG_9}}, 6'b0, 8);
    check("midrst_frames", 32'(frames - f0), 32'd1);
    check("midrst_digits9", 32'(last_digits), 32'h999999);
    check("midrst_fcnt", 32'(last_cnt), 32'd1);

    // Blank digits are legal
    scan({SEG_9, SEG_BLANK, SEG_7, SEG_0, SEG_BLANK, SEG_8}, 6'b0, 8);
    check("blank_digits", 32'(last_digits), 32'h9F70F8);
    check("blank_err", 32'(last_err), 32'h0);
    check("blank_cnt", 32'(last_cnt), 32'd2);

    // 256 frames with dp on digit 0; counter wraps
    do_reset();
    f0 = frames;
    for (int k = 0; k < 256; k++) begin
      scan({6{SEG_8}}, 6'b000001, 6);
      check("wrap_dp", 32'(last_dp), 32'h01);
      if (k == 254) check("wrap_cnt255", 32'(last_cnt), 32'd255);
    end
    check("wrap_frames", 32'(frames - f0), 32'd256);
    check("wrap_cnt0", 32'(o_frame_cnt), 32'd0);
    check("wrap_digits", 32'(o_digits), 32'h888888);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
